// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: word width, next-PC select codes
// and the bubble instruction.
package mips_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_JR     = 2'b11
  } pc_src_e;

  // sll $0,$0,0
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset/flush insert a bubble, stall holds,
// otherwise the fetched word and its PC+4 are captured as valid.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_WORD_P = NOP_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [WORD_W-1:0] inst,
  input  logic [WORD_W-1:0] pc_plus4,
  output logic [WORD_W-1:0] if_id_inst,
  output logic [WORD_W-1:0] if_id_pc_plus4,
  output logic              if_id_valid
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      if_id_inst     <= NOP_WORD_P;
      if_id_pc_plus4 <= '0;
      if_id_valid    <= 1'b0;
    end else if (!stall) begin
      if_id_inst     <= inst;
      if_id_pc_plus4 <= pc_plus4;
      if_id_valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select and IF/ID register.
// Define IF_PERF_CNT_EN to add the fetch_count / stall_count outputs.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic [31:0] inst_addr,
  input  logic [31:0] instruction,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] target;
  logic [WORD_W-1:0] pc_next;

  assign inst_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  always_comb begin
    target = '0;
    case (pc_src_e'(pc_src))
      PC_SRC_BRANCH: target = branch_target;
      PC_SRC_JUMP:   target = jump_target;
      PC_SRC_JR:     target = jr_target;
      default:       target = '0;
    endcase
  end

  // A redirect comes from further down the pipe, so it overrides stall.
  always_comb begin
    pc_next = pc_plus4;
    if (pc_src != PC_SRC_SEQ) pc_next = word_align(target);
    else if (stall)           pc_next = pc;
  end

  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_next;
  end

  if_id_reg #(
    .NOP_WORD_P(NOP_WORD)
  ) u_if_id_reg (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .inst           (instruction),
    .pc_plus4       (pc_plus4),
    .if_id_inst     (if_id_inst),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid)
  );

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (!flush && !stall) fetch_count <= fetch_count + 32'd1;
      if (stall)            stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios then random traffic,
// checked against a cycle-level behavioural model of the fetch stage.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [1:0]  pc_src;
  logic [31:0] branch_target, jump_target, jr_target;
  logic [31:0] inst_addr, instruction;
  logic [31:0] if_id_inst, if_id_pc_plus4;
  logic        if_id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic [31:0] m_pc, m_inst, m_pc4;
  logic        m_valid;
  logic [31:0] m_fetch, m_stall;

  always #5 clk = ~clk;

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .pc_src         (pc_src),
    .branch_target  (branch_target),
    .jump_target    (jump_target),
    .jr_target      (jr_target),
    .inst_addr      (inst_addr),
    .instruction    (instruction),
    .if_id_inst     (if_id_inst),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  // instruction memory: a distinct word for every word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[17:2]};
  endfunction

  assign instruction = mem_word(inst_addr);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, clock the DUT, compare.
  task automatic do_cycle(input logic r, input logic s, input logic f,
                          input logic [1:0] src, input logic [31:0] bt,
                          input logic [31:0] jt, input logic [31:0] jrt);
    logic [31:0] tgt;
    rst = r; stall = s; flush = f; pc_src = src;
    branch_target = bt; jump_target = jt; jr_target = jrt;
    tgt = (src == 2'd1) ? bt : (src == 2'd2) ? jt : jrt;
    tgt = tgt & 32'hFFFF_FFFC;
    if (r || f) begin
      m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (!s) begin
      m_inst = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
    end
    if (r) begin
      m_fetch = 0; m_stall = 0;
    end else begin
      if (!s && !f) m_fetch = m_fetch + 1;
      if (s) m_stall = m_stall + 1;
    end
    if (r)              m_pc = 32'h0;
    else if (src != 0)  m_pc = tgt;
    else if (!s)        m_pc = m_pc + 32'd4;
    @(posedge clk);
    #1;
    check_val("inst_addr", inst_addr, m_pc);
    check_val("if_id_inst", if_id_inst, m_inst);
    check_val("if_id_pc_plus4", if_id_pc_plus4, m_pc4);
    check_val("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
`ifdef IF_PERF_CNT_EN
    check_val("fetch_count", fetch_count, m_fetch);
    check_val("stall_count", stall_count, m_stall);
`endif
  endtask

  task automatic seq(input logic s, input logic f);
    do_cycle(1'b0, s, f, 2'd0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_fetch = 0; m_stall = 0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; pc_src = 2'd0;
    branch_target = 0; jump_target = 0; jr_target = 0;
    #2;

    do_cycle(1'b1, 1'b0, 1'b0, 2'd0, 0, 0, 0);
    do_cycle(1'b1, 1'b0, 1'b0, 2'd0, 0, 0, 0);
    check_val("reset_addr", inst_addr, 32'h0);
    check_val("reset_valid", {31'b0, if_id_valid}, 32'h0);

    // free run: 0,4,8 fetched; IF/ID holds the word at 4 when pc = 8
    seq(0, 0);
    seq(0, 0);
    check_val("run_addr", inst_addr, 32'h8);
    check_val("run_pc4", if_id_pc_plus4, 32'h8);
    check_val("run_inst", if_id_inst, mem_word(32'h4));
    // stall two cycles at pc = 8
    seq(1, 0);
    seq(1, 0);
    check_val("stall_addr", inst_addr, 32'h8);
    check_val("stall_inst", if_id_inst, mem_word(32'h4));
    seq(0, 0);
    check_val("release_addr", inst_addr, 32'hC);
    check_val("release_inst", if_id_inst, mem_word(32'h8));
    seq(0, 0);

    // branch from 16 to misaligned 0x43 -> 0x40, delay slot kept
    do_cycle(0, 0, 0, 2'd1, 32'h0000_0043, 0, 0);
    check_val("branch_addr", inst_addr, 32'h40);
    check_val("branch_slot", if_id_inst, mem_word(32'h10));
    check_val("branch_slot_v", {31'b0, if_id_valid}, 32'h1);
    do_cycle(0, 0, 0, 2'd2, 0, 32'h10, 0);
    do_cycle(0, 0, 1, 2'd1, 32'h0000_0043, 0, 0);
    check_val("bflush_addr", inst_addr, 32'h40);
    check_val("bflush_inst", if_id_inst, 32'h0);

    // jump during stall: redirect wins, IF/ID holds; then stall+flush
    seq(0, 0);
    do_cycle(0, 1, 0, 2'd2, 0, 32'h100, 0);
    check_val("jstall_addr", inst_addr, 32'h100);
    check_val("jstall_inst", if_id_inst, mem_word(32'h40));
    do_cycle(0, 1, 1, 2'd0, 0, 0, 0);
    check_val("sflush_valid", {31'b0, if_id_valid}, 32'h0);
    check_val("sflush_addr", inst_addr, 32'h100);

    // wrap at top of address space
    do_cycle(0, 0, 0, 2'd3, 0, 0, 32'hFFFF_FFFF);
    check_val("jr_addr", inst_addr, 32'hFFFF_FFFC);
    seq(0, 0);
    check_val("wrap_addr", inst_addr, 32'h0);
    check_val("wrap_pc4", if_id_pc_plus4, 32'h0);
    check_val("wrap_inst", if_id_inst, mem_word(32'hFFFF_FFFC));

    // reset during a stalled redirect
    do_cycle(1, 1, 0, 2'd2, 0, 32'h200, 0);
    check_val("rst_mid_addr", inst_addr, 32'h0);
    seq(0, 0);
    check_val("rst_first_pc4", if_id_pc_plus4, 32'h4);

`ifdef IF_PERF_CNT_EN
    do_cycle(1, 0, 0, 2'd0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      seq((i == 2 || i == 5 || i == 6), (i == 8));
    check_val("perf_fetch", fetch_count, 32'd6);
    check_val("perf_stall", stall_count, 32'd3);
    do_cycle(1, 0, 0, 2'd0, 0, 0, 0);
    check_val("perf_clr_fetch", fetch_count, 32'd0);
    check_val("perf_clr_stall", stall_count, 32'd0);
`endif

    // random traffic
    for (int i = 0; i < 500; i++) begin
      logic r, s, f;
      logic [1:0] src;
      r   = ($urandom_range(0, 99) < 3);
      s   = ($urandom_range(0, 99) < 25);
      f   = ($urandom_range(0, 99) < 15);
      src = ($urandom_range(0, 99) < 60) ? 2'd0 : 2'($urandom_range(1, 3));
      do_cycle(r, s, f, src, $urandom, $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the pipelined MIPS core. It holds the program counter and drives the combinational instruction-memory address. It selects the next PC from sequential, branch, jump or jump-register sources and registers the fetched word plus PC+4 into the IF/ID pipeline register. It honours stall and flush requests from the hazard unit, and the ID stage consumes its outputs.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned)
NOP_WORD, 32'h0000_0000, instruction injected into IF/ID on reset or flush (sll $0,$0,0)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
stall  input  1  hazard unit: hold PC and IF/ID contents
flush  input  1  hazard unit: replace IF/ID contents with bubble
pc_src  input  2  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 jr
branch_target  input  32  branch target from ID/EX
jump_target  input  32  J/JAL target
jr_target  input  32  JR register value
inst_addr  output  32  current PC; drives instruction-memory Address
instruction  input  32  word returned combinationally by instruction memory
if_id_inst  output  32  registered instruction
if_id_pc_plus4  output  32  registered PC+4 of that instruction
if_id_valid  output  1  1 = IF/ID holds a real fetch, 0 = bubble

Behaviour:
- Reset values: pc = RESET_PC, so inst_addr = RESET_PC. if_id_inst = NOP_WORD, if_id_pc_plus4 = 0, if_id_valid = 0.
- inst_addr = pc, purely combinational from the register. The memory returns the 4 big-endian bytes at pc..pc+3 in the same cycle.
- pc_plus4 = pc + 4, modulo 2^32: 32'hFFFF_FFFC wraps to 0.
- Targets are forced word-aligned: bits [1:0] of the selected target are replaced with 00.
- PC update on each clk edge, in priority order:
  - rst → pc = RESET_PC.
  - pc_src != 00 → pc = selected target. A redirect beats stall, because the redirect originates later in the pipe.
  - stall → pc holds.
  - otherwise → pc = pc_plus4.
- IF/ID update on each clk edge, in priority order:
  - rst or flush → bubble: NOP_WORD, pc_plus4 = 0, valid = 0.
  - stall → hold all three fields.
  - otherwise → capture instruction, pc_plus4, valid = 1.
- Redirect without flush is legal and models a delay slot: the instruction fetched in the redirect cycle still enters IF/ID.
- stall and flush together: flush wins for IF/ID. The PC follows the PC rule above.
- Reset asserted mid-stall or mid-redirect: reset wins everywhere. The first fetch after rst deasserts is from RESET_PC.
- Latency: an instruction appears on if_id_* exactly one cycle after its address is driven, absent stall.

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds outputs fetch_count[31:0] and stall_count[31:0], both cleared by rst.
  - fetch_count increments on every cycle IF/ID captures with valid = 1.
  - stall_count increments on every cycle stall = 1 and rst = 0.
  - Both wrap at 2^32.
- Undefined: no counters and no extra ports; logic is identical otherwise.

Decomposition:
- Shared package mips_pkg holds:
  - PC_SRC_SEQ/BRANCH/JUMP/JR encodings (2-bit)
  - NOP_WORD default
  - WORD_W = 32
- One natural sub-module, if_id_reg: the IF/ID pipeline register with its flush/stall/reset priority.
- PC register and next-PC mux stay in if_stage.

Test Plan:
- Reset, then 4 free-run cycles with memory preloaded → inst_addr sequence 0, 4, 8, 12; if_id_pc_plus4 = 4, 8, 12 with matching words; valid = 1 from cycle 2.
- stall held 2 cycles at pc = 8 → inst_addr stays 8 and IF/ID holds the word at 4 for 2 cycles. On release, pc goes to 12 and the word at 8 is captured.
- pc_src = 01 with branch_target = 32'h0000_0043 at pc = 16 → next pc = 32'h40. The word at 16 enters IF/ID (no flush). Repeat with flush = 1: IF/ID gets NOP_WORD, valid = 0.
- pc_src = 10 and stall = 1 together, jump_target = 32'h100 → pc = 32'h100 and IF/ID holds. Then stall + flush → IF/ID becomes a bubble.
- Force pc to 32'hFFFF_FFFC, run sequentially → next inst_addr = 0 and if_id_pc_plus4 = 0.
- With IF_PERF_CNT_EN: 10 cycles containing 3 stalls and 1 flush → fetch_count = 6, stall_count = 3; rst clears both to 0.
